// File: rtl/sync_fifo_wconv.sv
// sync_fifo_wconv: single-clock FIFO that packs RATIO write words into one read word, oldest word in the LSBs.
// Optional macro SYNC_FIFO_SHOWAHEAD_EN selects first-word-fall-through reads; otherwise reads have 1-cycle latency.
module sync_fifo_wconv #(
   parameter int WR_WIDTH = 8,
   parameter int RATIO    = 2,
   parameter int WR_DEPTH = 256,
   parameter int AF_LEVEL = 240,
   parameter int AW       = $clog2(WR_DEPTH)
) (
   input  logic                               sys_clk,
   input  logic                               sys_rst,
   input  logic                               wr_req,
   input  logic [WR_WIDTH-1:0]                wr_data,
   input  logic                               rd_req,
   output logic [WR_WIDTH*RATIO-1:0]          rd_data,
   output logic                               rd_valid,
   output logic                               wr_full,
   output logic                               wr_almost_full,
   output logic [AW:0]                        wr_usedw,
   output logic                               rd_empty,
   output logic [AW-$clog2(RATIO):0]          rd_usedw,
   output logic                               overflow,
   output logic                               underflow
);

   localparam int LOG_R = $clog2(RATIO);
   localparam int LW    = (LOG_R > 0) ? LOG_R : 1;
   localparam int ROWS  = WR_DEPTH / RATIO;
   localparam int RAW   = AW - LOG_R;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(WR_DEPTH);
   localparam logic [AW:0] RATIO_C = (AW+1)'(RATIO);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] ONE_C   = (AW+1)'(1);

   logic [AW-1:0]  wr_ptr_reg;
   logic [RAW-1:0] rd_row_reg;
   logic [RAW-1:0] rd_row_next;
   logic [AW:0]    usedw_reg;
   logic [AW:0]    usedw_next;
   logic [AW:0]    rd_sub;
   logic           wr_full_reg;
   logic           af_reg;
   logic           rd_empty_reg;
   logic           overflow_reg;
   logic           underflow_reg;
   logic           rd_valid_reg;
   logic           rd_valid_next;

   logic           wr_acc;
   logic           rd_acc;
   logic           ram_rd_en;
   logic [RAW-1:0] ram_rd_addr;
   logic [RAW-1:0] wr_row;
   logic [LW-1:0]  wr_lane;

   // The read pointer always sits on a read-word boundary, so only its row part is kept.
   generate
      if (LOG_R == 0) begin : g_lane_single
         assign wr_lane = '0;
         assign wr_row  = wr_ptr_reg;
      end else begin : g_lane_multi
         assign wr_lane = wr_ptr_reg[LOG_R-1:0];
         assign wr_row  = wr_ptr_reg[AW-1:LOG_R];
      end
   endgenerate

   always_comb begin
      wr_acc      = wr_req && !wr_full_reg;
      rd_acc      = rd_req && !rd_empty_reg;
      rd_sub      = rd_acc ? RATIO_C : '0;
      rd_row_next = rd_acc ? rd_row_reg + RAW'(1) : rd_row_reg;
      usedw_next  = usedw_reg;
      if (wr_acc)
         usedw_next = usedw_next + ONE_C;
      usedw_next  = usedw_next - rd_sub;
`ifdef SYNC_FIFO_SHOWAHEAD_EN
      // Prefetch only once the whole next word was already in RAM before this edge.
      rd_valid_next = (usedw_reg - rd_sub) >= RATIO_C;
      ram_rd_en     = rd_valid_next;
      ram_rd_addr   = rd_row_next;
`else
      rd_valid_next = rd_acc;
      ram_rd_en     = rd_acc;
      ram_rd_addr   = rd_row_reg;
`endif
   end

   // One narrow RAM per lane; lane gi holds write word gi of every read word.
   generate
      for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
         logic [WR_WIDTH-1:0] mem [0:ROWS-1];
         logic [WR_WIDTH-1:0] q_reg;

         always_ff @(posedge sys_clk) begin
            if (wr_acc && (wr_lane == LW'(gi)))
               mem[wr_row] <= wr_data;
         end

         always_ff @(posedge sys_clk) begin
            if (sys_rst)
               q_reg <= '0;
            else if (ram_rd_en)
               q_reg <= mem[ram_rd_addr];
         end

         assign rd_data[gi*WR_WIDTH +: WR_WIDTH] = q_reg;
      end
   endgenerate

   // Flags come from the count, never from pointer compares, and use only pre-edge state.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr_reg    <= '0;
         rd_row_reg    <= '0;
         usedw_reg     <= '0;
         wr_full_reg   <= 1'b0;
         af_reg        <= 1'b0;
         rd_empty_reg  <= 1'b1;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
         rd_valid_reg  <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         rd_row_reg    <= rd_row_next;
         usedw_reg     <= usedw_next;
         wr_full_reg   <= (usedw_next == DEPTH_C);
         af_reg        <= (usedw_next >= AF_C);
         rd_empty_reg  <= (usedw_next < RATIO_C);
         overflow_reg  <= wr_req && wr_full_reg;
         underflow_reg <= rd_req && rd_empty_reg;
         rd_valid_reg  <= rd_valid_next;
      end
   end

   assign rd_valid       = rd_valid_reg;
   assign wr_full        = wr_full_reg;
   assign wr_almost_full = af_reg;
   assign wr_usedw       = usedw_reg;
   assign rd_empty       = rd_empty_reg;
   assign rd_usedw       = usedw_reg[AW:LOG_R];
   assign overflow       = overflow_reg;
   assign underflow      = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_wconv.sv
// tb_sync_fifo_wconv: directed vector table plus hand sequences for fill/overflow, streaming and mid-burst reset.
// Build with SYNC_FIFO_SHOWAHEAD_EN to exercise the fall-through read sequence instead.
module tb_sync_fifo_wconv;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_req;
   logic [7:0]  wr_data;
   logic        rd_req;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        wr_full;
   logic        wr_almost_full;
   logic [8:0]  wr_usedw;
   logic        rd_empty;
   logic [7:0]  rd_usedw;
   logic        overflow;
   logic        underflow;

   int errors = 0;
   int checks = 0;

   sync_fifo_wconv #(
      .WR_WIDTH(8), .RATIO(2), .WR_DEPTH(256), .AF_LEVEL(240)
   ) dut (
      .sys_clk(clk), .sys_rst(rst),
      .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_full(wr_full), .wr_almost_full(wr_almost_full), .wr_usedw(wr_usedw),
      .rd_empty(rd_empty), .rd_usedw(rd_usedw),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [7:0]  wd;
      logic        rd;
      logic [15:0] rdata;
      logic        rv, empty, full, af;
      logic [8:0]  usedw;
      logic [7:0]  rdu;
      logic        ovf, unf;
   } vec_t;

   localparam logic [63:0] RESET_OUTS = {25'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0, 1'b0};

   function automatic vec_t mk(input logic wr, input logic [7:0] wd, input logic rd,
                               input logic [15:0] rdata, input logic rv, input logic empty,
                               input logic [8:0] usedw, input logic [7:0] rdu, input logic unf);
      vec_t v;
      v.wr = wr; v.wd = wd; v.rd = rd; v.rdata = rdata; v.rv = rv; v.empty = empty;
      v.full = 1'b0; v.af = 1'b0; v.usedw = usedw; v.rdu = rdu; v.ovf = 1'b0; v.unf = unf;
      return v;
   endfunction

   function automatic logic [63:0] outs();
      return {25'd0, rd_data, rd_valid, rd_empty, wr_full, wr_almost_full,
              wr_usedw, rd_usedw, overflow, underflow};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset is held with both requests active to show it wins over them.
   task automatic do_reset(input string tag);
      rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'hEE;
      step();
      step();
      check(tag, outs(), RESET_OUTS);
      rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h00;
   endtask

`ifndef SYNC_FIFO_SHOWAHEAD_EN
   vec_t vecs[16];

   task automatic run_table();
      vecs[0]  = mk(1'b1, 8'h11, 1'b0, 16'h0000, 1'b0, 1'b1, 9'd1, 8'd0, 1'b0);
      vecs[1]  = mk(1'b1, 8'h22, 1'b0, 16'h0000, 1'b0, 1'b0, 9'd2, 8'd1, 1'b0);
      vecs[2]  = mk(1'b1, 8'h33, 1'b0, 16'h0000, 1'b0, 1'b0, 9'd3, 8'd1, 1'b0);
      vecs[3]  = mk(1'b1, 8'h44, 1'b0, 16'h0000, 1'b0, 1'b0, 9'd4, 8'd2, 1'b0);
      vecs[4]  = mk(1'b0, 8'h00, 1'b1, 16'h2211, 1'b1, 1'b0, 9'd2, 8'd1, 1'b0);
      vecs[5]  = mk(1'b0, 8'h00, 1'b1, 16'h4433, 1'b1, 1'b1, 9'd0, 8'd0, 1'b0);
      vecs[6]  = mk(1'b0, 8'h00, 1'b0, 16'h4433, 1'b0, 1'b1, 9'd0, 8'd0, 1'b0);
      vecs[7]  = mk(1'b0, 8'h00, 1'b1, 16'h4433, 1'b0, 1'b1, 9'd0, 8'd0, 1'b1);
      vecs[8]  = mk(1'b1, 8'h5A, 1'b0, 16'h4433, 1'b0, 1'b1, 9'd1, 8'd0, 1'b0);
      vecs[9]  = mk(1'b0, 8'h00, 1'b1, 16'h4433, 1'b0, 1'b1, 9'd1, 8'd0, 1'b1);
      vecs[10] = mk(1'b1, 8'hA5, 1'b0, 16'h4433, 1'b0, 1'b0, 9'd2, 8'd1, 1'b0);
      vecs[11] = mk(1'b0, 8'h00, 1'b1, 16'hA55A, 1'b1, 1'b1, 9'd0, 8'd0, 1'b0);
      // A same-cycle write never makes the read legal.
      vecs[12] = mk(1'b1, 8'h01, 1'b1, 16'hA55A, 1'b0, 1'b1, 9'd1, 8'd0, 1'b1);
      vecs[13] = mk(1'b1, 8'h02, 1'b1, 16'hA55A, 1'b0, 1'b0, 9'd2, 8'd1, 1'b1);
      vecs[14] = mk(1'b1, 8'h03, 1'b1, 16'h0201, 1'b1, 1'b1, 9'd1, 8'd0, 1'b0);
      vecs[15] = mk(1'b0, 8'h00, 1'b0, 16'h0201, 1'b0, 1'b1, 9'd1, 8'd0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         wr_req = vecs[i].wr; wr_data = vecs[i].wd; rd_req = vecs[i].rd;
         step();
         $display("vec %0d: wr=%0b wd=%02h rd=%0b -> rd_data=%04h rd_valid=%0b usedw=%0d",
                  i, vecs[i].wr, vecs[i].wd, vecs[i].rd, rd_data, rd_valid, wr_usedw);
         check($sformatf("vec%0d", i), outs(),
               {25'd0, vecs[i].rdata, vecs[i].rv, vecs[i].empty, vecs[i].full, vecs[i].af,
                vecs[i].usedw, vecs[i].rdu, vecs[i].ovf, vecs[i].unf});
      end
      wr_req = 1'b0; rd_req = 1'b0;
   endtask

   task automatic run_fill();
      do_reset("reset_fill");
      for (int i = 0; i < 256; i++) begin
         wr_req = 1'b1; wr_data = 8'(i);
         step();
         if (i == 238) check("af_at_239", 64'(wr_almost_full), 64'd0);
         if (i == 239) check("af_at_240", 64'({wr_almost_full, wr_usedw}), 64'({1'b1, 9'd240}));
         if (i == 254) check("full_at_255", 64'(wr_full), 64'd0);
         if (i == 255) check("full_at_256", 64'({wr_full, wr_usedw, rd_usedw, overflow}),
                             64'({1'b1, 9'd256, 8'd128, 1'b0}));
      end
      wr_data = 8'hAA;
      step();
      $display("write 0xAA while full: overflow=%0b usedw=%0d", overflow, wr_usedw);
      check("ovf_aa", 64'({overflow, wr_full, wr_usedw}), 64'({1'b1, 1'b1, 9'd256}));
      // Full still blocks the write even though this cycle's read is accepted.
      wr_data = 8'hBB; rd_req = 1'b1;
      step();
      check("ovf_bb_rd", 64'({overflow, wr_full, wr_usedw, rd_valid, rd_data}),
            64'({1'b1, 1'b0, 9'd254, 1'b1, 16'h0100}));
      wr_req = 1'b0; rd_req = 1'b0;
      step();
      check("ovf_single", 64'(overflow), 64'd0);
      for (int k = 1; k < 128; k++) begin
         rd_req = 1'b1;
         step();
         check($sformatf("drain%0d", k), 64'({rd_valid, rd_data}),
               64'({1'b1, 8'(2*k+1), 8'(2*k)}));
      end
      rd_req = 1'b0;
      step();
      $display("drained: usedw=%0d rd_empty=%0b", wr_usedw, rd_empty);
      check("drain_end", 64'({wr_usedw, rd_empty, wr_almost_full, wr_full}),
            64'({9'd0, 1'b1, 1'b0, 1'b0}));
   endtask

   task automatic run_stream();
      int m;
      int k;
      int max_m;
      logic acc_r;
      do_reset("reset_stream");
      m = 0; k = 0; max_m = 0;
      for (int i = 0; i < 1000; i++) begin
         wr_req = 1'b1; wr_data = 8'(i);
         rd_req = (i >= 3) && (i % 2 == 1);
         acc_r = rd_req && (m >= 2);
         m = m + 1 - (acc_r ? 2 : 0);
         if (m > max_m) max_m = m;
         step();
         check($sformatf("stream_c%0d", i), 64'({wr_usedw, overflow, underflow, rd_valid}),
               64'({9'(m), 1'b0, 1'b0, acc_r}));
         if (acc_r) begin
            check($sformatf("stream_rd%0d", k), 64'(rd_data), 64'({8'(2*k+1), 8'(2*k)}));
            k++;
         end
      end
      wr_req = 1'b0; rd_req = 1'b0;
      $display("stream: %0d reads, peak usedw %0d", k, max_m);
      check("stream_bound", 64'(max_m <= 4), 64'd1);
   endtask

   task automatic run_midreset();
      do_reset("reset_mid");
      for (int i = 0; i < 102; i++) begin
         wr_req = 1'b1; wr_data = 8'(i + 1);
         step();
      end
      wr_req = 1'b0; rd_req = 1'b1;
      step();
      check("pre_reset", 64'({wr_usedw, rd_data}), 64'({9'd100, 16'h0201}));
      rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'h77;
      step();
      check("mid_reset", outs(), RESET_OUTS);
      rst = 1'b0; rd_req = 1'b0; wr_data = 8'hC1;
      step();
      wr_data = 8'hC2;
      step();
      wr_req = 1'b0; rd_req = 1'b1;
      step();
      $display("after reset read: rd_data=%04h", rd_data);
      check("post_reset_rd", 64'({rd_valid, rd_data, wr_usedw}), 64'({1'b1, 16'hC2C1, 9'd0}));
      rd_req = 1'b0;
   endtask
`else
   task automatic run_showahead();
      do_reset("reset_sa");
      wr_req = 1'b1; wr_data = 8'h01;
      step();
      wr_data = 8'h02;
      step();
      check("sa_empty", 64'({rd_empty, wr_usedw}), 64'({1'b0, 9'd2}));
      wr_req = 1'b0;
      step();
      $display("show-ahead: rd_valid=%0b rd_data=%04h", rd_valid, rd_data);
      check("sa_word", 64'({rd_valid, rd_data}), 64'({1'b1, 16'h0201}));
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      check("sa_ack", 64'({rd_empty, rd_valid, underflow}), 64'({1'b1, 1'b0, 1'b0}));
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      check("sa_unf", 64'(underflow), 64'd1);
   endtask
`endif

   initial begin
      rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h00;
`ifndef SYNC_FIFO_SHOWAHEAD_EN
      do_reset("reset_initial");
      run_table();
      run_fill();
      run_stream();
      run_midreset();
`else
      run_showahead();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
